// File: rtl/dtm_dmi_ctrl.sv
// JTAG DTM DMI sequencer: turns DMI scans into one outstanding DM request and returns the result at CAPTURE_DR.
// Owns dtmcs (sticky dmistat, dmireset, dmihardreset); everything runs in the tclk domain.
module dtm_dmi_ctrl #(
  parameter int ABITS     = 7,
  parameter int IDLE_HINT = 5,
  parameter int VERSION   = 1
) (
  input  logic             tclk,
  input  logic             trst,
  input  logic             cap_dmi,
  input  logic             upd_dmi,
  input  logic [ABITS+33:0] dmi_shift_in,
  output logic [ABITS+33:0] dmi_cap_out,
  input  logic             upd_dtmcs,
  input  logic [31:0]      dtmcs_shift_in,
  output logic [31:0]      dtmcs_cap_out,
  output logic             req_valid,
  input  logic             req_ready,
  output logic [ABITS-1:0] req_addr,
  output logic [31:0]      req_data,
  output logic [1:0]       req_op,
  input  logic             rsp_valid,
  output logic             rsp_ready,
  input  logic [31:0]      rsp_data,
  input  logic [1:0]       rsp_op
);

  localparam logic [2:0] LP_IDLE_HINT = 3'(IDLE_HINT);
  localparam logic [5:0] LP_ABITS     = 6'(ABITS);
  localparam logic [3:0] LP_VERSION   = 4'(VERSION);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_RSP  = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [1:0]       r_sticky;
  logic [1:0]       w_sticky_nxt;
  logic             r_abort;
  logic [ABITS-1:0] r_addr;
  logic [31:0]      r_data;
  logic [1:0]       r_op;

  logic       w_upd_rw;
  logic       w_busy;
  logic       w_start;
  logic       w_rsp_done;
  logic       w_rsp_keep;
  logic       w_rsp_err;
  logic       w_dmireset;
  logic       w_hardreset;
  logic [1:0] w_status;
  logic       w_unused;

  assign w_upd_rw    = upd_dmi && (dmi_shift_in[1:0] == 2'd1 || dmi_shift_in[1:0] == 2'd2);
  assign w_busy      = (r_state != S_IDLE);
  assign w_start     = w_upd_rw && !w_busy && (r_sticky == 2'd0);
  assign w_rsp_done  = (r_state == S_RSP) && rsp_valid;
  assign w_dmireset  = upd_dtmcs && dtmcs_shift_in[16];
  assign w_hardreset = upd_dtmcs && dtmcs_shift_in[17];
  // A hard reset landing on the completion edge also drops that response.
  assign w_rsp_keep  = w_rsp_done && !r_abort && !w_hardreset;
  assign w_rsp_err   = (rsp_op == 2'd2) || (rsp_op == 2'd3);
  assign w_unused    = ^{dtmcs_shift_in[31:18], dtmcs_shift_in[15:0]};

  always_comb begin
    w_state_nxt  = r_state;
    w_sticky_nxt = r_sticky;
    req_valid    = 1'b0;
    rsp_ready    = 1'b0;
    case (r_state)
      S_IDLE: if (w_start) w_state_nxt = S_REQ;
      S_REQ: begin
        req_valid = 1'b1;
        if (req_ready) w_state_nxt = S_RSP;
      end
      S_RSP: begin
        rsp_ready = 1'b1;
        if (rsp_valid) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
    // First error wins; busy from a capture outranks a failing response on the same edge.
    if (w_dmireset || w_hardreset) begin
      w_sticky_nxt = 2'd0;
    end else if (r_sticky == 2'd0) begin
      if ((cap_dmi || w_upd_rw) && w_busy) begin
        w_sticky_nxt = 2'd3;
      end else if (w_rsp_keep && w_rsp_err) begin
        w_sticky_nxt = 2'd2;
      end
    end
  end

  always_ff @(posedge tclk or negedge trst) begin
    if (!trst) begin
      r_state  <= S_IDLE;
      r_sticky <= 2'd0;
      r_abort  <= 1'b0;
      r_addr   <= '0;
      r_data   <= '0;
      r_op     <= 2'd0;
    end else begin
      r_state  <= w_state_nxt;
      r_sticky <= w_sticky_nxt;
      if (w_rsp_done) begin
        r_abort <= 1'b0;
      end else if (w_hardreset && w_busy) begin
        r_abort <= 1'b1;
      end
      if (w_start) begin
        r_addr <= dmi_shift_in[ABITS+33:34];
        r_data <= dmi_shift_in[33:2];
        r_op   <= dmi_shift_in[1:0];
      end else if (w_rsp_keep && r_op == 2'd1 && rsp_op == 2'd0) begin
        r_data <= rsp_data;
      end
    end
  end

  assign w_status      = (r_sticky != 2'd0) ? r_sticky : (w_busy ? 2'd3 : 2'd0);
  assign dmi_cap_out   = {r_addr, r_data, w_status};
  assign dtmcs_cap_out = {14'b0, 1'b0, 1'b0, 1'b0, LP_IDLE_HINT, r_sticky, LP_ABITS, LP_VERSION};
  assign req_addr      = r_addr;
  assign req_data      = r_data;
  assign req_op        = r_op;

endmodule

// File: tb/tb_dtm_dmi_ctrl.sv
// Bench for dtm_dmi_ctrl: directed vector table, hand sequences for abort/collision/reset, then random traffic vs a transaction model.
module tb_dtm_dmi_ctrl;
  logic        tclk = 1'b0;
  logic        trst;
  logic        cap_dmi, upd_dmi, upd_dtmcs;
  logic [40:0] dmi_shift_in, dmi_cap_out;
  logic [31:0] dtmcs_shift_in, dtmcs_cap_out;
  logic        req_valid, req_ready, rsp_valid, rsp_ready;
  logic [6:0]  req_addr;
  logic [31:0] req_data, rsp_data;
  logic [1:0]  req_op, rsp_op;

  int checks = 0;
  int errors = 0;

  always #5 tclk = ~tclk;

  dtm_dmi_ctrl dut (
    .tclk(tclk), .trst(trst), .cap_dmi(cap_dmi), .upd_dmi(upd_dmi),
    .dmi_shift_in(dmi_shift_in), .dmi_cap_out(dmi_cap_out),
    .upd_dtmcs(upd_dtmcs), .dtmcs_shift_in(dtmcs_shift_in), .dtmcs_cap_out(dtmcs_cap_out),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_data(req_data), .req_op(req_op), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_op(rsp_op)
  );

  typedef struct packed {
    logic        up, cap, dt;
    logic [1:0]  dtb;
    logic [40:0] dmi;
    logic        rr, rv;
    logic [31:0] rd;
    logic [1:0]  ro;
    logic        e_rv, e_rr;
    logic [40:0] e_cap;
    logic [1:0]  e_stk;
  } vec_t;

  vec_t tbl[$];

  function automatic logic [40:0] mk(logic [6:0] a, logic [31:0] d, logic [1:0] o);
    return {a, d, o};
  endfunction

  function automatic logic [31:0] dtmcs_exp(logic [1:0] stk);
    return 32'h0000_5071 | (32'(stk) << 10);
  endfunction

  function automatic vec_t v(logic up, logic cap, logic dt, logic [1:0] dtb, logic [40:0] dmi,
                             logic rr, logic rv, logic [31:0] rd, logic [1:0] ro,
                             logic e_rv, logic e_rr, logic [40:0] e_cap, logic [1:0] e_stk);
    vec_t r;
    r.up = up; r.cap = cap; r.dt = dt; r.dtb = dtb; r.dmi = dmi;
    r.rr = rr; r.rv = rv; r.rd = rd; r.ro = ro;
    r.e_rv = e_rv; r.e_rr = e_rr; r.e_cap = e_cap; r.e_stk = e_stk;
    return r;
  endfunction

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  task automatic idle();
    cap_dmi = 0; upd_dmi = 0; upd_dtmcs = 0; dmi_shift_in = '0; dtmcs_shift_in = '0;
    req_ready = 0; rsp_valid = 0; rsp_data = '0; rsp_op = 2'd0;
  endtask

  task automatic tick();
    @(posedge tclk);
    #1;
  endtask

  // Transaction-level reference: one outstanding access, sticky status, pending-drop flag.
  bit          m_busy, m_sent, m_drop;
  logic [1:0]  m_stk;
  logic [6:0]  m_addr;
  logic [31:0] m_data;
  logic [1:0]  m_op;

  function automatic logic [40:0] m_cap();
    logic [1:0] st;
    st = (m_stk != 0) ? m_stk : (m_busy ? 2'd3 : 2'd0);
    return {m_addr, m_data, st};
  endfunction

  task automatic m_step();
    bit rw, hard, clr, fin;
    rw   = upd_dmi && (dmi_shift_in[1:0] inside {2'd1, 2'd2});
    hard = upd_dtmcs && dtmcs_shift_in[17];
    clr  = upd_dtmcs && (dtmcs_shift_in[16] || dtmcs_shift_in[17]);
    fin  = m_busy && m_sent && rsp_valid;
    if (clr) m_stk = 0;
    else if (m_stk == 0 && m_busy && (cap_dmi || rw)) m_stk = 3;
    else if (m_stk == 0 && fin && !m_drop && rsp_op inside {2'd2, 2'd3}) m_stk = 2;
    if (fin && !m_drop && !hard && m_op == 1 && rsp_op == 0) m_data = rsp_data;
    if (fin) m_drop = 0;
    else if (hard && m_busy) m_drop = 1;
    if (fin) begin
      m_busy = 0; m_sent = 0;
    end else if (m_busy && !m_sent && req_ready) begin
      m_sent = 1;
    end else if (!m_busy && rw && m_stk == 0 && !clr) begin
      m_busy = 1;
      {m_addr, m_data, m_op} = dmi_shift_in;
    end
  endtask

  initial begin
    idle();
    trst = 0;
    #12;
    check("reset_req_valid", 64'(req_valid), 64'd0);
    check("reset_rsp_ready", 64'(rsp_ready), 64'd0);
    check("reset_dmi_cap", 64'(dmi_cap_out), 64'd0);
    check("reset_dtmcs", 64'(dtmcs_cap_out), 64'h5071);
    @(posedge tclk); #1 trst = 1;

    //         up cap dt dtb  dmi                            rr rv rd            ro  erv err e_cap                             stk
    tbl.push_back(v(1,0,0,0, mk(7'h10,0,1),                  0,0,0,            0,  0,0, mk(0,0,0),                         0));
    tbl.push_back(v(0,0,0,0, 0,                              0,0,0,            0,  1,0, mk(7'h10,0,3),                     0));
    tbl.push_back(v(0,0,0,0, 0,                              0,0,0,            0,  1,0, mk(7'h10,0,3),                     0));
    tbl.push_back(v(0,0,0,0, 0,                              1,0,0,            0,  1,0, mk(7'h10,0,3),                     0));
    tbl.push_back(v(0,0,0,0, 0,                              0,1,32'hDEADBEEF, 0,  0,1, mk(7'h10,0,3),                     0));
    tbl.push_back(v(0,1,0,0, 0,                              0,0,0,            0,  0,0, mk(7'h10,32'hDEADBEEF,0),          0));
    tbl.push_back(v(1,0,0,0, mk(7'h04,32'h12345678,2),       0,0,0,            0,  0,0, mk(7'h10,32'hDEADBEEF,0),          0));
    tbl.push_back(v(0,0,0,0, 0,                              1,0,0,            0,  1,0, mk(7'h04,32'h12345678,3),          0));
    tbl.push_back(v(0,1,0,0, 0,                              0,0,0,            0,  0,1, mk(7'h04,32'h12345678,3),          0));
    tbl.push_back(v(0,0,0,0, 0,                              0,1,32'hAAAA5555, 0,  0,1, mk(7'h04,32'h12345678,3),          3));
    tbl.push_back(v(1,0,0,0, mk(7'h20,0,1),                  0,0,0,            0,  0,0, mk(7'h04,32'h12345678,3),          3));
    tbl.push_back(v(0,0,0,0, 0,                              0,0,0,            0,  0,0, mk(7'h04,32'h12345678,3),          3));
    tbl.push_back(v(0,0,1,1, 0,                              0,0,0,            0,  0,0, mk(7'h04,32'h12345678,3),          3));
    tbl.push_back(v(1,0,0,0, mk(7'h20,0,1),                  0,0,0,            0,  0,0, mk(7'h04,32'h12345678,0),          0));
    tbl.push_back(v(0,0,0,0, 0,                              1,0,0,            0,  1,0, mk(7'h20,0,3),                     0));
    tbl.push_back(v(0,0,0,0, 0,                              0,1,32'hCAFEF00D, 2,  0,1, mk(7'h20,0,3),                     0));
    tbl.push_back(v(0,1,0,0, 0,                              0,0,0,            0,  0,0, mk(7'h20,0,2),                     2));
    tbl.push_back(v(1,0,0,0, mk(7'h21,5,2),                  0,0,0,            0,  0,0, mk(7'h20,0,2),                     2));
    tbl.push_back(v(0,0,0,0, 0,                              0,0,0,            0,  0,0, mk(7'h20,0,2),                     2));
    tbl.push_back(v(0,0,1,1, 0,                              0,0,0,            0,  0,0, mk(7'h20,0,2),                     2));
    tbl.push_back(v(1,0,0,0, mk(7'h33,32'h77,0),             0,0,0,            0,  0,0, mk(7'h20,0,0),                     0));
    tbl.push_back(v(1,0,0,0, mk(7'h34,32'h88,3),             0,0,0,            0,  0,0, mk(7'h20,0,0),                     0));
    tbl.push_back(v(0,1,0,0, 0,                              0,0,0,            0,  0,0, mk(7'h20,0,0),                     0));
    tbl.push_back(v(0,0,0,0, 0,                              0,0,0,            0,  0,0, mk(7'h20,0,0),                     0));
    tbl.push_back(v(1,0,0,0, mk(7'h40,1,1),                  0,0,0,            0,  0,0, mk(7'h20,0,0),                     0));
    tbl.push_back(v(1,0,0,0, mk(7'h41,2,2),                  0,0,0,            0,  1,0, mk(7'h40,1,3),                     0));
    tbl.push_back(v(0,0,0,0, 0,                              1,0,0,            0,  1,0, mk(7'h40,1,3),                     3));
    tbl.push_back(v(0,0,0,0, 0,                              0,1,32'h99,       0,  0,1, mk(7'h40,1,3),                     3));
    tbl.push_back(v(0,0,0,0, 0,                              0,0,0,            0,  0,0, mk(7'h40,32'h99,3),                3));
    tbl.push_back(v(0,0,1,1, 0,                              0,0,0,            0,  0,0, mk(7'h40,32'h99,3),                3));
    tbl.push_back(v(0,0,0,0, 0,                              0,0,0,            0,  0,0, mk(7'h40,32'h99,0),                0));

    foreach (tbl[i]) begin
      upd_dmi = tbl[i].up; cap_dmi = tbl[i].cap; upd_dtmcs = tbl[i].dt;
      dtmcs_shift_in = {14'b0, tbl[i].dtb, 16'b0}; dmi_shift_in = tbl[i].dmi;
      req_ready = tbl[i].rr; rsp_valid = tbl[i].rv; rsp_data = tbl[i].rd; rsp_op = tbl[i].ro;
      @(negedge tclk);
      check($sformatf("vec%0d_req_valid", i), 64'(req_valid), 64'(tbl[i].e_rv));
      check($sformatf("vec%0d_rsp_ready", i), 64'(rsp_ready), 64'(tbl[i].e_rr));
      check($sformatf("vec%0d_dmi_cap", i), 64'(dmi_cap_out), 64'(tbl[i].e_cap));
      check($sformatf("vec%0d_dtmcs", i), 64'(dtmcs_cap_out), 64'(dtmcs_exp(tbl[i].e_stk)));
      tick();
    end
    idle();

    // Hard reset while the request waits: request held, response dropped.
    upd_dmi = 1; dmi_shift_in = mk(7'h05, 0, 1); tick(); idle();
    upd_dtmcs = 1; dtmcs_shift_in = 32'h0002_0000;
    @(negedge tclk); check("hard_req_valid", 64'(req_valid), 64'd1);
    tick(); idle();
    for (int k = 0; k < 3; k++) begin
      @(negedge tclk); check($sformatf("hard_hold%0d", k), 64'(req_valid), 64'd1);
      tick();
    end
    req_ready = 1;
    @(negedge tclk); check("hard_req_accept", 64'(req_valid), 64'd1);
    tick(); idle();
    rsp_valid = 1; rsp_data = 32'h11112222;
    @(negedge tclk); check("hard_rsp_ready", 64'(rsp_ready), 64'd1);
    tick(); idle();
    @(negedge tclk);
    check("hard_dropped_cap", 64'(dmi_cap_out), 64'(mk(7'h05, 0, 0)));
    check("hard_dtmcs", 64'(dtmcs_cap_out), 64'h5071);
    check("hard_idle", 64'({req_valid, rsp_ready}), 64'd0);
    tick();
    upd_dmi = 1; dmi_shift_in = mk(7'h06, 0, 1); tick(); idle();
    req_ready = 1; tick(); idle();
    rsp_valid = 1; rsp_data = 32'h33334444; tick(); idle();
    @(negedge tclk); check("post_abort_read", 64'(dmi_cap_out), 64'(mk(7'h06, 32'h33334444, 0)));
    tick();

    // Capture on the response-completion edge: busy reported, data still stored.
    upd_dmi = 1; dmi_shift_in = mk(7'h07, 0, 1); tick(); idle();
    req_ready = 1; tick(); idle();
    rsp_valid = 1; rsp_data = 32'h55556666; cap_dmi = 1;
    @(negedge tclk); check("coll_cap", 64'(dmi_cap_out), 64'(mk(7'h07, 0, 3)));
    tick(); idle();
    @(negedge tclk);
    check("coll_after", 64'(dmi_cap_out), 64'(mk(7'h07, 32'h55556666, 3)));
    check("coll_dtmcs", 64'(dtmcs_cap_out), 64'h5C71);
    tick();
    upd_dtmcs = 1; dtmcs_shift_in = 32'h0001_0000; tick(); idle();

    // Asynchronous reset in the middle of RSP.
    upd_dmi = 1; dmi_shift_in = mk(7'h08, 32'hABCD, 2); tick(); idle();
    req_ready = 1; tick(); idle();
    @(negedge tclk); check("trst_pre_rsp", 64'(rsp_ready), 64'd1);
    #2 trst = 0;
    #1;
    check("trst_req_valid", 64'(req_valid), 64'd0);
    check("trst_rsp_ready", 64'(rsp_ready), 64'd0);
    check("trst_dmi_cap", 64'(dmi_cap_out), 64'd0);
    check("trst_dtmcs", 64'(dtmcs_cap_out), 64'h5071);
    @(posedge tclk); #1 trst = 1;

    // Random traffic against the reference model.
    m_busy = 0; m_sent = 0; m_drop = 0; m_stk = 0; m_addr = 0; m_data = 0; m_op = 0;
    for (int c = 0; c < 3000; c++) begin
      int r;
      idle();
      r = $urandom_range(0, 99);
      if (r < 10) begin
        upd_dmi = 1;
        dmi_shift_in = {7'($urandom), 32'($urandom), 2'($urandom)};
      end else if (r < 18) begin
        cap_dmi = 1;
      end else if (r < 22) begin
        upd_dtmcs = 1;
        dtmcs_shift_in = $urandom;
      end
      req_ready = ($urandom_range(0, 2) == 0);
      rsp_valid = ($urandom_range(0, 2) == 0);
      rsp_data  = $urandom;
      r = $urandom_range(0, 3);
      rsp_op = (r == 2) ? 2'd2 : (r == 3) ? 2'd3 : 2'd0;
      @(negedge tclk);
      check("rnd_req_valid", 64'(req_valid), 64'(m_busy && !m_sent));
      check("rnd_rsp_ready", 64'(rsp_ready), 64'(m_busy && m_sent));
      check("rnd_dmi_cap", 64'(dmi_cap_out), 64'(m_cap()));
      check("rnd_dtmcs", 64'(dtmcs_cap_out), 64'(dtmcs_exp(m_stk)));
      if (m_busy && !m_sent)
        check("rnd_req_fields", 64'({req_addr, req_data, req_op}), 64'({m_addr, m_data, m_op}));
      @(posedge tclk);
      m_step();
      #1;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
